// File: rtl/calc_pkg.sv
// Shared constants for the calculator: operation codes and the hex seven-segment glyphs.
package calc_pkg;

   localparam logic [2:0] OP_LOAD_ADD = 3'd0;
   localparam logic [2:0] OP_SUB      = 3'd1;
   localparam logic [2:0] OP_MUL      = 3'd2;
   localparam logic [2:0] OP_DIV      = 3'd3;
   localparam logic [2:0] OP_MOD      = 3'd4;
   localparam logic [2:0] OP_SQR      = 3'd5;

   // Bit order {g,f,e,d,c,b,a}; a 0 lights the segment.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
      return SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/calculator_hex.sv
// ALU and running result register; one operation per op_pulse, applied at the next clock edge.
module calculator_hex
   import calc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        op_pulse,
   input  logic [2:0]  func,
   input  logic [7:0]  num1,
   input  logic [7:0]  num2,
   output logic [31:0] cal_result
);

   logic [31:0] opa;
   logic [31:0] opb;
   logic [31:0] result_nxt;

   assign opa = {24'd0, num1};
   assign opb = {24'd0, num2};

   always_comb begin
      result_nxt = cal_result;
      case (func)
         OP_LOAD_ADD: result_nxt = opa + opb;
         OP_SUB:      result_nxt = cal_result - opb;
         OP_MUL:      result_nxt = cal_result * opb;
         // Divide by zero saturates; modulo by zero keeps the old value.
         OP_DIV:      result_nxt = (opb == 32'd0) ? 32'hFFFF_FFFF : cal_result / opb;
         OP_MOD:      result_nxt = (opb == 32'd0) ? cal_result : cal_result % opb;
         OP_SQR:      result_nxt = cal_result * cal_result;
         default:     result_nxt = cal_result;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cal_result <= 32'd0;
      end else if (op_pulse) begin
         cal_result <= result_nxt;
      end
   end

endmodule

// File: rtl/calculator_unit.sv
// Calculator board top: button synchronizer and edge detector, ALU instance, 8-digit hex scan.
// Segment and enable outputs are registered and only change on scan slot boundaries.
module calculator_unit
   import calc_pkg::*;
#(
   parameter int SCAN_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   input  logic [2:0] func,
   input  logic [7:0] num1,
   input  logic [7:0] num2,
   output logic [7:0] led_en,
   output logic       led_ca,
   output logic       led_cb,
   output logic       led_cc,
   output logic       led_cd,
   output logic       led_ce,
   output logic       led_cf,
   output logic       led_cg,
   output logic       led_dp
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

   logic        btn_meta;
   logic        btn_sync;
   logic        btn_prev;
   logic [1:0]  sync_vld;
   logic        btn_armed;
   logic        op_pulse;
   logic [31:0] cal_result;

   logic [CW-1:0] scan_cnt;
   logic [2:0]    scan_idx;
   logic [2:0]    scan_next;
   logic          slot_end;
   logic [6:0]    seg;

   // An edge only counts once a genuinely sampled low has been seen since reset,
   // so a button already held high through reset release does not fire.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         btn_prev  <= 1'b0;
         sync_vld  <= 2'b00;
         btn_armed <= 1'b0;
         op_pulse  <= 1'b0;
      end else begin
         btn_meta  <= button;
         btn_sync  <= btn_meta;
         btn_prev  <= btn_sync;
         sync_vld  <= {sync_vld[0], 1'b1};
         btn_armed <= btn_armed | (sync_vld[1] & ~btn_sync);
         op_pulse  <= btn_armed & btn_sync & ~btn_prev;
      end
   end

   calculator_hex u_calculator_hex (
      .clk        (clk),
      .rst        (rst),
      .op_pulse   (op_pulse),
      .func       (func),
      .num1       (num1),
      .num2       (num2),
      .cal_result (cal_result)
   );

   assign slot_end  = (scan_cnt == CNT_MAX);
   assign scan_next = scan_idx + 3'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= 3'd0;
         led_en   <= 8'hFE;
         seg      <= hex_seg(4'h0);
      end else if (slot_end) begin
         scan_cnt <= '0;
         scan_idx <= scan_next;
         led_en   <= ~(8'd1 << scan_next);
         seg      <= hex_seg(cal_result[4*scan_next +: 4]);
      end else begin
         scan_cnt <= scan_cnt + CW'(1);
      end
   end

   assign led_ca = seg[0];
   assign led_cb = seg[1];
   assign led_cc = seg[2];
   assign led_cd = seg[3];
   assign led_ce = seg[4];
   assign led_cf = seg[5];
   assign led_cg = seg[6];
   assign led_dp = 1'b1;

endmodule

// File: tb/tb_calculator_unit.sv
// Bench for calculator_unit: directed presses, random presses against an arithmetic model, display scan.
module tb_calculator_unit;

   localparam int SD = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       button;
   logic [2:0] func;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [7:0] led_en;
   logic       led_ca, led_cb, led_cc, led_cd, led_ce, led_cf, led_cg, led_dp;
   logic [6:0] seg_obs;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] model = 32'd0;

   // Lit segments per hex digit, written a..g from msb to lsb, 1 = lit.
   logic [6:0] lit [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   always #5 clk = ~clk;

   assign seg_obs = {led_cg, led_cf, led_ce, led_cd, led_cc, led_cb, led_ca};

   calculator_unit #(.SCAN_DIV(SD)) dut (
      .clk    (clk),
      .rst    (rst),
      .button (button),
      .func   (func),
      .num1   (num1),
      .num2   (num2),
      .led_en (led_en),
      .led_ca (led_ca),
      .led_cb (led_cb),
      .led_cc (led_cc),
      .led_cd (led_cd),
      .led_ce (led_ce),
      .led_cf (led_cf),
      .led_cg (led_cg),
      .led_dp (led_dp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_op(input logic [31:0] r, input logic [2:0] f,
                                          input logic [7:0] a, input logic [7:0] b);
      longint unsigned rr = r;
      longint unsigned aa = a;
      longint unsigned bb = b;
      case (f)
         3'd0: return 32'(aa + bb);
         3'd1: return 32'(rr - bb);
         3'd2: return 32'(rr * bb);
         3'd3: return (bb == 0) ? 32'hFFFF_FFFF : 32'(rr / bb);
         3'd4: return (bb == 0) ? r : 32'(rr % bb);
         3'd5: return 32'(rr * rr);
         default: return r;
      endcase
   endfunction

   // Active-low {g..a} pattern of a hex digit.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      logic [6:0] m;
      logic [6:0] o;
      m = lit[n];
      for (int j = 0; j < 7; j++) o[j] = ~m[6-j];
      return o;
   endfunction

   task automatic press(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b, input int hold);
      @(negedge clk);
      func = f; num1 = a; num2 = b; button = 1'b1;
      repeat (hold) @(negedge clk);
      button = 1'b0;
      repeat (6) @(negedge clk);
      model = ref_op(model, f, a, b);
      check($sformatf("result f%0d", f), dut.u_calculator_hex.cal_result, model);
   endtask

   task automatic display_check(input string tag);
      int t;
      logic [7:0] cur;
      repeat (8*SD + 4) @(negedge clk);
      t = 0;
      while (led_en == 8'hFE && t < 4*SD) begin @(negedge clk); t++; end
      t = 0;
      while (led_en != 8'hFE && t < 16*SD) begin @(negedge clk); t++; end
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s en%0d", tag, i), led_en, ~(32'd1 << i) & 32'hFF);
         check($sformatf("%s seg%0d", tag, i), seg_obs, glyph(model[4*i +: 4]));
         cur = led_en;
         t = 0;
         do begin @(negedge clk); t++; end while (led_en == cur && t < 4*SD);
         check($sformatf("%s slot%0d", tag, i), t, SD);
      end
      check($sformatf("%s dp", tag), led_dp, 1'b1);
   endtask

   logic [31:0] plan_exp [7] = '{32'h0000000A, 32'h00000078, 32'h00003840, 32'h00003778,
                                 32'h000006EF, 32'h00301321, 32'h00000001};
   logic [2:0]  plan_f   [7] = '{3'd0, 3'd2, 3'd5, 3'd1, 3'd3, 3'd5, 3'd4};
   logic [7:0]  plan_b   [7] = '{8'h04, 8'h0C, 8'h00, 8'hC8, 8'h08, 8'h00, 8'h08};

   initial begin
      rst = 1'b1; button = 1'b0; func = 3'd0; num1 = 8'd0; num2 = 8'd0;
      repeat (3) @(negedge clk);
      check("rst result", dut.u_calculator_hex.cal_result, 32'd0);
      check("rst led_en", led_en, 8'hFE);
      check("rst seg", seg_obs, 7'b1000000);
      check("rst dp", led_dp, 1'b1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         press(plan_f[i], 8'h06, plan_b[i], 2);
         check($sformatf("plan%0d", i), dut.u_calculator_hex.cal_result, plan_exp[i]);
      end

      press(3'd0, 8'h05, 8'h00, 3);
      press(3'd1, 8'h00, 8'h01, 100);
      check("hold once", dut.u_calculator_hex.cal_result, 32'd4);

      press(3'd0, 8'h00, 8'h00, 2);
      press(3'd1, 8'h00, 8'h01, 2);
      check("sub wrap", dut.u_calculator_hex.cal_result, 32'hFFFF_FFFF);
      press(3'd0, 8'hFF, 8'h01, 2);
      press(3'd5, 8'h00, 8'h00, 2);
      check("sq 100", dut.u_calculator_hex.cal_result, 32'h0001_0000);
      press(3'd5, 8'h00, 8'h00, 2);
      check("sq wrap", dut.u_calculator_hex.cal_result, 32'd0);

      press(3'd0, 8'h09, 8'h00, 2);
      press(3'd3, 8'h00, 8'h00, 2);
      check("div0", dut.u_calculator_hex.cal_result, 32'hFFFF_FFFF);
      press(3'd0, 8'h07, 8'h00, 2);
      press(3'd4, 8'h00, 8'h00, 2);
      check("mod0", dut.u_calculator_hex.cal_result, 32'd7);
      press(3'd6, 8'h12, 8'h34, 2);
      press(3'd7, 8'h56, 8'h78, 2);
      check("nop67", dut.u_calculator_hex.cal_result, 32'd7);

      // Reset lands in the same cycle as the operate pulse.
      press(3'd0, 8'hE9, 8'h00, 2);
      press(3'd2, 8'h00, 8'h14, 2);
      check("r1234", dut.u_calculator_hex.cal_result, 32'h1234);
      @(negedge clk);
      func = 3'd0; num1 = 8'h11; num2 = 8'h22; button = 1'b1;
      repeat (3) @(negedge clk);
      check("pulse live", dut.op_pulse, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      model = 32'd0;
      check("rst wins", dut.u_calculator_hex.cal_result, model);
      check("rst en", led_en, 8'hFE);
      check("rst seg0", seg_obs, 7'b1000000);
      check("rst dp1", led_dp, 1'b1);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("held thru rst", dut.u_calculator_hex.cal_result, model);
      button = 1'b0;
      repeat (5) @(negedge clk);
      press(3'd0, 8'h03, 8'h04, 2);

      // Build 89ABCDEF one nibble at a time: S <- S*16 - (15-d) keeps S = prefix+1.
      press(3'd0, 8'h09, 8'h00, 2);
      for (int d = 9; d <= 14; d++) begin
         press(3'd2, 8'h00, 8'h10, 2);
         press(3'd1, 8'h00, 8'(15 - d), 2);
      end
      press(3'd2, 8'h00, 8'h10, 2);
      press(3'd1, 8'h00, 8'h01, 2);
      check("build", dut.u_calculator_hex.cal_result, 32'h89AB_CDEF);
      display_check("scan");

      for (int i = 0; i < 40; i++) begin
         logic [2:0] f;
         logic [7:0] a;
         logic [7:0] b;
         f = 3'($urandom_range(0, 7));
         a = 8'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         press(f, a, b, int'($urandom_range(1, 12)));
      end
      press(3'd0, 8'($urandom), 8'($urandom), 2);
      press(3'd2, 8'h00, 8'($urandom_range(2, 255)), 2);
      press(3'd5, 8'h00, 8'h00, 2);
      display_check("rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
